mem_access: RTL and testbench

Memory-access stage of the 32-bit MIPS pipeline, between the EXE/MEM register and the write-back stage. Takes the address, store data, destination register and WB/MEM control bits from EXE/MEM, runs one word access on a req/ack data-memory bus, and registers the MEM/WB values for write-back. While an access is outstanding it raises `stall` so upstream pipeline registers hold. It also detects misaligned addresses and bus timeouts.

---
 rtl/mips_pkg.sv | 36 +++
 rtl/mem_wb_reg.sv | 43 ++++
 rtl/mem_access.sv | 157 +++++++++++++++
 tb/tb_mem_access.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: control-bit positions, FSM encoding, bus payload.
package mips_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned WB_W  = 2;
  localparam int unsigned MEM_W = 3;

  // WB control bit positions
  localparam int unsigned REGWRITE = 1;
  localparam int unsigned MEMTOREG = 0;

  // MEM control bit positions
  localparam int unsigned MEMREAD  = 1;
  localparam int unsigned MEMWRITE = 0;
  localparam int unsigned BRANCH   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Data-memory request payload held on the bus for the whole access.
  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } bus_req_t;

  // Load data handed to write-back: stores retire with zero read data.
  function automatic logic [XLEN-1:0] load_data(input logic is_write,
                                                input logic [XLEN-1:0] rdata);
    return is_write ? '0 : rdata;
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; a bubble retires the slot with WB control cleared.
module mem_wb_reg
  import mips_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             i_bubble,
  input  logic [XLEN-1:0]  i_alu_result,
  input  logic [REG_W-1:0] i_dest_reg,
  input  logic [WB_W-1:0]  i_wb,
  input  logic [XLEN-1:0]  i_read_data,
  output logic [XLEN-1:0]  o_alu_result,
  output logic [REG_W-1:0] o_dest_reg,
  output logic [WB_W-1:0]  o_wb,
  output logic [XLEN-1:0]  o_read_data
);

  logic [XLEN-1:0]  r_alu_result;
  logic [REG_W-1:0] r_dest_reg;
  logic [WB_W-1:0]  r_wb;
  logic [XLEN-1:0]  r_read_data;

  // Capture the retiring slot every cycle; bubbles carry no write-back effect.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_alu_result <= '0;
      r_dest_reg   <= '0;
      r_wb         <= '0;
      r_read_data  <= '0;
    end else begin
      r_alu_result <= i_alu_result;
      r_dest_reg   <= i_dest_reg;
      r_wb         <= i_bubble ? '0 : i_wb;
      r_read_data  <= i_bubble ? '0 : i_read_data;
    end
  end

  assign o_alu_result = r_alu_result;
  assign o_dest_reg   = r_dest_reg;
  assign o_wb         = r_wb;
  assign o_read_data  = r_read_data;

endmodule

// File: rtl/mem_access.sv
// MIPS memory-access stage: one word access per instruction on a req/ack bus,
// with pipeline stall, misalignment abort and bus-timeout abort.
module mem_access
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] aluResult,
  input  logic [31:0] writeData,
  input  logic [4:0]  destReg,
  input  logic [1:0]  WB,
  input  logic [2:0]  MEM,
  output logic        stall,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  input  logic [31:0] memRdata,
  input  logic        memAck,
  output logic [31:0] readDataOut,
  output logic [31:0] aluResultOut,
  output logic [4:0]  destRegOut,
  output logic [1:0]  WBOut,
  output logic        misaligned,
  output logic        busError
);

  // Last WAIT cycle count before the access is abandoned.
  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [TO_W-1:0] r_cnt;
  logic [TO_W-1:0] w_cnt_nxt;
  logic            r_req;
  logic            w_req_nxt;
  bus_req_t        r_bus;
  bus_req_t        w_bus_nxt;
  logic            r_mis;
  logic            w_mis_nxt;
  logic            r_berr;
  logic            w_berr_nxt;

  logic            w_stall;
  logic            w_bubble;
  logic [XLEN-1:0] w_rdata;

  logic            w_access;
  logic            w_is_write;
  logic            w_misaligned;
  logic            w_unused_branch;

  // Decode of the held EXE/MEM control; a read+write request is a write.
  assign w_access        = MEM[MEMREAD] | MEM[MEMWRITE];
  assign w_is_write      = MEM[MEMWRITE];
  assign w_misaligned    = (aluResult[1:0] != 2'b00);
  assign w_unused_branch = MEM[BRANCH];

  // State, timeout counter, bus request and abort flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_bus   <= '0;
      r_mis   <= 1'b0;
      r_berr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_req   <= w_req_nxt;
      r_bus   <= w_bus_nxt;
      r_mis   <= w_mis_nxt;
      r_berr  <= w_berr_nxt;
    end
  end

  // Next-state, bus and retire decisions for the instruction in this stage.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_req_nxt   = r_req;
    w_bus_nxt   = r_bus;
    w_mis_nxt   = 1'b0;
    w_berr_nxt  = 1'b0;
    w_stall     = 1'b0;
    w_bubble    = 1'b1;
    w_rdata     = '0;

    case (r_state)
      IDLE: begin
        if (!w_access) begin
          w_bubble = 1'b0;
        end else if (w_misaligned) begin
          w_mis_nxt = 1'b1;
        end else begin
          w_req_nxt       = 1'b1;
          w_bus_nxt.we    = w_is_write;
          w_bus_nxt.addr  = aluResult;
          w_bus_nxt.wdata = writeData;
          w_cnt_nxt       = '0;
          w_state_nxt     = WAIT;
          w_stall         = 1'b1;
        end
      end

      WAIT: begin
        if (memAck) begin
          // Ack wins over a timeout landing in the same cycle.
          w_req_nxt   = 1'b0;
          w_state_nxt = IDLE;
          w_bubble    = 1'b0;
          w_rdata     = load_data(w_is_write, memRdata);
        end else if (r_cnt == CNT_LAST) begin
          // Release the pipeline; the faulting instruction retires as a bubble.
          w_req_nxt   = 1'b0;
          w_berr_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_stall   = 1'b1;
          w_cnt_nxt = r_cnt + TO_W'(1);
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_req_nxt   = 1'b0;
      end
    endcase
  end

  mem_wb_reg u_mem_wb_reg (
    .clock        (clock),
    .reset        (reset),
    .i_bubble     (w_bubble),
    .i_alu_result (aluResult),
    .i_dest_reg   (destReg),
    .i_wb         (WB),
    .i_read_data  (w_rdata),
    .o_alu_result (aluResultOut),
    .o_dest_reg   (destRegOut),
    .o_wb         (WBOut),
    .o_read_data  (readDataOut)
  );

  assign stall      = w_stall;
  assign memReq     = r_req;
  assign memWe      = r_bus.we;
  assign memAddr    = r_bus.addr;
  assign memWdata   = r_bus.wdata;
  assign misaligned = r_mis;
  assign busError   = r_berr;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: random and directed instructions, a bus
// responder, and a monitor that checks each retired instruction's WB outputs.
module tb_mem_access;

  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned TO_W    = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] aluResult;
  logic [31:0] writeData;
  logic [4:0]  destReg;
  logic [1:0]  WB;
  logic [2:0]  MEM;
  logic        stall;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [31:0] memRdata;
  logic        memAck;
  logic [31:0] readDataOut;
  logic [31:0] aluResultOut;
  logic [4:0]  destRegOut;
  logic [1:0]  WBOut;
  logic        misaligned;
  logic        busError;

  mem_access #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .aluResult    (aluResult),
    .writeData    (writeData),
    .destReg      (destReg),
    .WB           (WB),
    .MEM          (MEM),
    .stall        (stall),
    .memReq       (memReq),
    .memWe        (memWe),
    .memAddr      (memAddr),
    .memWdata     (memWdata),
    .memRdata     (memRdata),
    .memAck       (memAck),
    .readDataOut  (readDataOut),
    .aluResultOut (aluResultOut),
    .destRegOut   (destRegOut),
    .WBOut        (WBOut),
    .misaligned   (misaligned),
    .busError     (busError)
  );

  always #5 clock = ~clock;

  // Expected retirement of one instruction.
  typedef struct {
    logic [1:0]  wb;
    logic [31:0] alu;
    logic [4:0]  dest;
    logic [31:0] rdata;
    bit          mis;
    bit          berr;
    int          stall_cycles;
    bit          chk_data;
  } exp_t;

  // Expected bus transaction plus how the responder should answer it.
  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;   // ack in the delay-th cycle of memReq; 0 = never
    bit          late;    // ack once memReq has already dropped
    logic [31:0] rdata;
    int          high;    // cycles memReq is expected to stay high
  } bus_t;

  exp_t sb_q[$];
  bus_t bus_q[$];

  int n_checks = 0;
  int n_errors = 0;
  bit tb_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%08h required=0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_stall"},        32'(stall),        32'h0);
    chk({tag, "_memReq"},       32'(memReq),       32'h0);
    chk({tag, "_memWe"},        32'(memWe),        32'h0);
    chk({tag, "_memAddr"},      memAddr,           32'h0);
    chk({tag, "_memWdata"},     memWdata,          32'h0);
    chk({tag, "_readDataOut"},  readDataOut,       32'h0);
    chk({tag, "_aluResultOut"}, aluResultOut,      32'h0);
    chk({tag, "_destRegOut"},   32'(destRegOut),   32'h0);
    chk({tag, "_WBOut"},        32'(WBOut),        32'h0);
    chk({tag, "_misaligned"},   32'(misaligned),   32'h0);
    chk({tag, "_busError"},     32'(busError),     32'h0);
  endtask

  // Present one instruction, record its expected outcome, hold it until accepted.
  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic [4:0] d,
                       input logic [1:0] wb, input logic [2:0] mem,
                       input int delay, input bit late, input logic [31:0] rd);
    exp_t e;
    bus_t b;
    bit   access;
    bit   wr;
    bit   mis;
    bit   acked;
    int   guard;
    access = mem[1] | mem[0];
    wr     = mem[0];
    mis    = (a[1:0] != 2'b00);
    acked  = (delay >= 1) && (delay <= int'(TIMEOUT));
    e.alu = a; e.dest = d; e.wb = 2'b00; e.rdata = 32'h0;
    e.mis = 1'b0; e.berr = 1'b0; e.stall_cycles = 0; e.chk_data = 1'b0;
    if (!access) begin
      e.wb = wb; e.chk_data = 1'b1;
    end else if (mis) begin
      e.mis = 1'b1;
    end else begin
      e.stall_cycles = acked ? delay : int'(TIMEOUT);
      if (acked) begin
        e.wb = wb; e.chk_data = 1'b1;
        e.rdata = wr ? 32'h0 : rd;
      end else begin
        e.berr = 1'b1;
      end
      b.we = wr; b.addr = a; b.wdata = wd; b.delay = delay;
      b.late = late && !acked; b.rdata = rd; b.high = e.stall_cycles;
      bus_q.push_back(b);
    end
    sb_q.push_back(e);
    aluResult = a; writeData = wd; destReg = d; WB = wb; MEM = mem; tb_valid = 1'b1;
    guard = 0;
    while (1) begin
      @(negedge clock);
      if (!stall) break;
      guard++;
      if (guard > 4 * int'(TIMEOUT) + 8) begin
        n_errors++;
        $display("FAIL stall_bound: stall high for %0d cycles, required at most %0d", guard, TIMEOUT);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $fatal(1, "stall never released");
      end
    end
    @(posedge clock); #1;
  endtask

  // Reset the stage in its second WAIT cycle, then offer a stray ack.
  task automatic reset_mid_wait();
    bus_t b;
    b.we = 1'b0; b.addr = 32'h300; b.wdata = 32'hA5A5_0001; b.delay = 0;
    b.late = 1'b1; b.rdata = 32'hFEED_FACE; b.high = 2;
    bus_q.push_back(b);
    aluResult = 32'h300; writeData = 32'hA5A5_0001; destReg = 5'd7; WB = 2'b11; MEM = 3'b010;
    tb_valid = 1'b1;
    @(posedge clock); #1;             // WAIT cycle 1
    @(posedge clock); #1;             // WAIT cycle 2
    reset = 1'b1; tb_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    aluResult = 32'h0; writeData = 32'h0; destReg = 5'd0; WB = 2'b00; MEM = 3'b000;
    @(negedge clock);
    check_all_zero("mid_wait_reset");
    @(posedge clock); #1;
    chk("post_reset_memReq", 32'(memReq), 32'h0);
    chk("post_reset_WBOut",  32'(WBOut),  32'h0);
  endtask

  // Bus responder: checks each request and answers per the queued plan.
  initial begin : responder
    bus_t cur;
    bit   active;
    bit   acked;
    int   k;
    active = 1'b0; acked = 1'b0; k = 0;
    cur.we = 1'b0; cur.addr = 32'h0; cur.wdata = 32'h0; cur.delay = 0;
    cur.late = 1'b0; cur.rdata = 32'h0; cur.high = 0;
    memAck = 1'b0;
    memRdata = 32'h0;
    forever begin
      @(posedge clock); #1;
      if (memReq) begin
        if (!active) begin
          if (bus_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_memReq: request with none expected (t=%0t)", $time);
            cur.delay = 0; cur.late = 1'b0; cur.high = 0;
          end else begin
            cur = bus_q.pop_front();
            chk("memWe",    32'(memWe), 32'(cur.we));
            chk("memAddr",  memAddr,    cur.addr);
            chk("memWdata", memWdata,   cur.wdata);
          end
          active = 1'b1; acked = 1'b0; k = 0;
        end
        k++;
        if (!acked && cur.delay == k) begin
          memAck = 1'b1; acked = 1'b1; memRdata = cur.rdata;
        end else begin
          memAck = 1'b0; memRdata = $urandom;
        end
      end else begin
        if (active) begin
          chk("memReq_high_cycles", 32'(k), 32'(cur.high));
          memAck = cur.late && !acked;
          active = 1'b0;
        end else begin
          memAck = 1'b0;
        end
        memRdata = $urandom;
      end
    end
  end

  // Monitor: a stall-free cycle retires the instruction; compare on the next cycle.
  int prev_kind = 0;       // 0 none, 1 stalled, 2 retired
  int stall_run = 0;
  int retired_stall = 0;

  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      prev_kind = 0;
      stall_run = 0;
    end else begin
      if (prev_kind == 2) begin
        if (sb_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL retire_unexpected: retirement with empty scoreboard (t=%0t)", $time);
        end else begin
          e = sb_q.pop_front();
          chk("WBOut",        32'(WBOut),        32'(e.wb));
          chk("misaligned",   32'(misaligned),   32'(e.mis));
          chk("busError",     32'(busError),     32'(e.berr));
          chk("stall_cycles", 32'(retired_stall), 32'(e.stall_cycles));
          if (e.chk_data) begin
            chk("aluResultOut", aluResultOut,     e.alu);
            chk("destRegOut",   32'(destRegOut),  32'(e.dest));
            chk("readDataOut",  readDataOut,      e.rdata);
          end
        end
      end else if (prev_kind == 1) begin
        chk("stall_bubble_WBOut",   32'(WBOut),      32'h0);
        chk("stall_bubble_flags",   32'({misaligned, busError}), 32'h0);
      end
      if (!tb_valid) begin
        prev_kind = 0;
      end else if (stall) begin
        prev_kind = 1;
        stall_run++;
      end else begin
        prev_kind = 2;
        retired_stall = stall_run;
        stall_run = 0;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1, "time limit");
  end

  initial begin : driver
    logic [31:0] r;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [1:0]  wb;
    logic [2:0]  mem;
    int          kind;
    int          delay;
    bit          late;

    reset = 1'b1;
    aluResult = 32'h0; writeData = 32'h0; destReg = 5'd0; WB = 2'b00; MEM = 3'b000;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_all_zero("reset");
    @(posedge clock); #1;
    reset = 1'b0;

    // ALU op passes straight through
    issue(32'h10, 32'h0, 5'd3, 2'b10, 3'b000, 0, 1'b0, 32'h0);
    // lw, ack in the 3rd request cycle
    issue(32'h100, 32'h0, 5'd8, 2'b11, 3'b010, 3, 1'b0, 32'hDEADBEEF);
    // sw, immediate ack
    issue(32'h204, 32'h12345678, 5'd0, 2'b00, 3'b001, 1, 1'b0, 32'h0);
    // misaligned lw
    issue(32'h102, 32'h0, 5'd9, 2'b11, 3'b010, 2, 1'b0, 32'h0);
    // lw with no ack, then a late ack that must be ignored
    issue(32'h180, 32'h0, 5'd10, 2'b11, 3'b010, 0, 1'b1, 32'hCAFEF00D);
    // lw acked in the same cycle the timeout would fire
    issue(32'h184, 32'h0, 5'd11, 2'b11, 3'b010, 4, 1'b0, 32'h0BADF00D);
    // read+write together behaves as a store
    issue(32'h208, 32'h55AA55AA, 5'd12, 2'b10, 3'b011, 2, 1'b0, 32'h77777777);
    // reset during WAIT, then a normal lw
    reset_mid_wait();
    issue(32'h300, 32'h0, 5'd13, 2'b11, 3'b010, 2, 1'b0, 32'h13579BDF);

    for (int i = 0; i < 200; i++) begin
      r     = $urandom;
      wd    = $urandom;
      rd    = $urandom;
      wb    = 2'($urandom);
      mem   = 3'($urandom);
      kind  = $urandom_range(0, 4);
      delay = $urandom_range(0, TIMEOUT + 2);
      late  = 1'($urandom);
      a     = {r[31:2], 2'b00};
      case (kind)
        0: begin mem[1:0] = 2'b00; a = r; end
        1: mem[1:0] = 2'b10;
        2: mem[1:0] = 2'b01;
        3: mem[1:0] = 2'b11;
        default: begin
          mem[1:0] = 2'($urandom_range(1, 3));
          a[1:0]   = 2'($urandom_range(1, 3));
        end
      endcase
      issue(a, wd, 5'($urandom), wb, mem, delay, late, rd);
    end

    tb_valid = 1'b0;
    aluResult = 32'h0; writeData = 32'h0; destReg = 5'd0; WB = 2'b00; MEM = 3'b000;
    @(negedge clock);
    @(negedge clock);
    #1;
    chk("scoreboard_drained", 32'(sb_q.size()),  32'h0);
    chk("bus_plan_drained",   32'(bus_q.size()), 32'h0);
    chk("idle_memReq",        32'(memReq),       32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
